led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern generator that drives a bank of `NUM_LEDS` outputs with selectable animations: ripple up, ripple down, bounce and fill/drain. It extends the fixed 8-LED ripple design with the following:
- a programmable step prescaler,
- run-time mode selection,
- an enable,
- a step strobe.

It sits between the board clock and the LED pins in the lab top level, and is exercised by a self-checking bench.

## Interface
Parameters:
- `NUM_LEDS`, 8, LED count; legal range is 2 or more.
- `DIV_W`, 24, prescaler counter width.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  high: animation runs; low: freeze.
- `mode`  in  2  0 ripple up, 1 ripple down, 2 bounce, 3 fill/drain.
- `div`  in  DIV_W  step period minus one, in clk cycles.
- `leds`  out  NUM_LEDS  registered LED pattern; bit 0 is the lowest LED.
- `step`  out  1  one-cycle pulse, high in the cycle `leds` takes a new pattern.

## Operation
- **Reset values** (asynchronous, while `rst_n` is 0):
  - `leds` = 1 (bit 0 only), `step` = 0.
  - Prescaler count `cnt` = 0.
  - Registered mode `mode_q` = 0.
  - Bounce direction = UP; fill phase = FILL.
- **Prescaler**: while `enable` is 1, `cnt` increments each cycle. When `cnt >= div`, a tick fires and `cnt` returns to 0.
  - `div` = 0 gives a tick every cycle.
  - The `>=` compare means that if `div` is lowered below the current `cnt`, a tick fires on the next enabled cycle.
- **Tick**: on a tick, `leds` advances one step according to `mode_q`, and `step` is 1 for exactly that cycle.
- **Mode 0 (ripple up)**: one-hot value rotates left; bit N-1 wraps to bit 0.
- **Mode 1 (ripple down)**: one-hot value rotates right; bit 0 wraps to bit N-1.
- **Mode 2 (bounce)**: one-hot value shifts left while state is UP and right while state is DOWN.
  - Arriving at bit N-1 switches the state to DOWN; arriving at bit 0 switches it to UP.
  - End LEDs are not repeated, so the period is 2N-2 steps.
- **Mode 3 (fill/drain)**:
  - FILL phase: `leds` = (leds<<1)|1 until all ones, then phase switches to DRAIN.
  - DRAIN phase: `leds` = leds>>1 until 0, then phase switches to FILL.
  - The period is 2N steps, covering 0 up to all-ones and back.
- **Mode change**: when `mode` differs from `mode_q` (checked every cycle, regardless of `enable`), the next clock does all of the following:
  - loads `mode_q` = `mode`;
  - loads the start pattern for the new mode: mode 0 or 2 = bit 0 (direction UP); mode 1 = bit N-1; mode 3 = 0 (phase FILL);
  - clears `cnt`;
  - drives `step` = 0.

  A tick coinciding with a mode change is discarded; the restart wins.
- **Enable low**: `cnt`, `leds`, direction and phase all hold, and `step` = 0. Mode changes still restart the pattern.
- **Reset mid-operation**: all state returns to the reset values immediately, without waiting for `clk`.

## Timing
- Steady state: with constant `div` = D and `enable` = 1, `leds` changes every D+1 cycles.
- After reset release, or after a mode restart, with `enable` = 1: the first update occurs at the (D+1)th rising edge.
- `step` and the new `leds` value become visible after the same edge, so they are aligned.
- Output latency from the tick condition is one clock; `leds` is fully registered with no combinational path from any input.
- `enable` low at edge k suppresses any tick at edge k. Counting resumes from the held `cnt`.

## Configuration
- `LED_PATTERN_PWM_EN` defined:
  - adds port `duty  in  4`;
  - adds a free-running 4-bit PWM counter `pwm`, reset to 0;
  - the pin output becomes `leds` AND (`pwm` < `duty`) on every bit;
  - `duty` = 0 gives all LEDs dark; `duty` = 15 gives a 15/16 duty cycle;
  - `step` and the internal pattern are unaffected.
- `LED_PATTERN_PWM_EN` undefined: no `duty` port, and `leds` is driven directly from the pattern register.

## Test plan
- **Ripple up**: reset, mode=0, div=3, enable=1 → `leds` goes 01h→02h→04h…→80h→01h, one update every 4 cycles, with `step` high on each update.
- **Bounce**: mode=2, div=0 → sequence 01,02,04,…,80,40,…,02,01,02; 80h and 01h each appear once per 14-step period.
- **Fill/drain**: mode=3, div=0 → 00,01,03,07,…,FF,7F,3F,…,01,00,01 (16-step period).
- **Mode change with tick coincident**: switch to mode 1 at the same cycle as a tick → next `leds` = 80h, `step` = 0, `cnt` = 0; first step is then 40h, D+1 cycles later.
- **Enable, div, reset boundaries**:
  - drop `enable` for 10 cycles mid-count → `leds` and `cnt` frozen, no `step`; resumes with the remaining count;
  - lower `div` from 100 to 2 while `cnt` = 50 → tick on the next cycle;
  - assert `rst_n` low between edges → `leds` = 01h immediately.
- **PWM (`LED_PATTERN_PWM_EN`)**:
  - `duty` = 4 → each lit LED is high 4 of every 16 cycles;
  - `duty` = 0 → `leds` stays 0 while `step` still pulses.

Source files
------------

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// Purpose:
//   Drives a bank of NUM_LEDS outputs with a selectable animation that advances
//   one step per prescaler tick: ripple up, ripple down, bounce, fill/drain.
//
// Parameters:
//   NUM_LEDS  number of LEDs (2 or more)
//   DIV_W     width of the step prescaler counter
//
// Ports:
//   clk       system clock, all state updates on its rising edge
//   rst_n     asynchronous active-low reset
//   enable    1: animation runs, 0: pattern and prescaler frozen
//   mode      0 ripple up, 1 ripple down, 2 bounce, 3 fill/drain
//   div       step period minus one, in clk cycles
//   duty      (LED_PATTERN_PWM_EN only) brightness, 0 = dark, 15 = 15/16
//   leds      registered LED pattern, bit 0 is the lowest LED
//   step      one-cycle pulse, high in the cycle leds takes a new pattern
//
// Handshake:
//   step acts as a valid strobe for leds with no ready/back-pressure: every
//   cycle with step = 1 carries a fresh animation step. A restart caused by a
//   mode change also reloads leds but leaves step low.
//
// Configuration macro:
//   LED_PATTERN_PWM_EN  adds the duty input and a 4-bit PWM dimmer on leds.
// -----------------------------------------------------------------------------
module led_pattern_gen #(
   parameter int NUM_LEDS = 8,
   parameter int DIV_W    = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [1:0]          mode,
   input  logic [DIV_W-1:0]    div,
`ifdef LED_PATTERN_PWM_EN
   input  logic [3:0]          duty,
`endif
   output logic [NUM_LEDS-1:0] leds,
   output logic                step
);

   localparam logic [NUM_LEDS-1:0] PAT_LOW  = {{(NUM_LEDS-1){1'b0}}, 1'b1};
   localparam logic [NUM_LEDS-1:0] PAT_HIGH = {1'b1, {(NUM_LEDS-1){1'b0}}};

   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
   typedef enum logic {PH_FILL, PH_DRAIN} phase_t;

   // All control state in one struct so it can be observed as a unit.
   typedef struct packed {
      logic [1:0] mode;
      dir_t       dir;
      phase_t     phase;
   } fsm_t;

   fsm_t                st_q;
   logic [NUM_LEDS-1:0] pat_q;
   logic [DIV_W-1:0]    cnt_q;
   logic                step_q;

   logic [NUM_LEDS-1:0] nxt_pat;
   dir_t                nxt_dir;
   phase_t              nxt_phase;
   logic [NUM_LEDS-1:0] start_pat;
   logic                mode_chg;
   logic                tick;

   assign mode_chg = (mode != st_q.mode);
   // >= rather than == so lowering div below the running count ticks at once.
   assign tick     = enable && (cnt_q >= div);

   // Next animation step for the currently registered mode.
   always_comb begin
      nxt_pat   = pat_q;
      nxt_dir   = st_q.dir;
      nxt_phase = st_q.phase;
      case (st_q.mode)
         2'd0: nxt_pat = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
         2'd1: nxt_pat = {pat_q[0], pat_q[NUM_LEDS-1:1]};
         2'd2: begin
            // Direction flips on arrival at an end, so ends are shown once.
            if (st_q.dir == DIR_UP) begin
               nxt_pat = {pat_q[NUM_LEDS-2:0], 1'b0};
               if (nxt_pat[NUM_LEDS-1]) nxt_dir = DIR_DOWN;
            end else begin
               nxt_pat = {1'b0, pat_q[NUM_LEDS-1:1]};
               if (nxt_pat[0]) nxt_dir = DIR_UP;
            end
         end
         default: begin
            if (st_q.phase == PH_FILL) begin
               nxt_pat = {pat_q[NUM_LEDS-2:0], 1'b1};
               if (&nxt_pat) nxt_phase = PH_DRAIN;
            end else begin
               nxt_pat = {1'b0, pat_q[NUM_LEDS-1:1]};
               if (nxt_pat == '0) nxt_phase = PH_FILL;
            end
         end
      endcase
   end

   // Restart pattern for the mode being switched to.
   always_comb begin
      case (mode)
         2'd1:    start_pat = PAT_HIGH;
         2'd3:    start_pat = '0;
         default: start_pat = PAT_LOW;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= '{mode: 2'd0, dir: DIR_UP, phase: PH_FILL};
         pat_q  <= PAT_LOW;
         cnt_q  <= '0;
         step_q <= 1'b0;
      end else if (mode_chg) begin
         // Restart wins over any coincident tick and over enable.
         st_q   <= '{mode: mode, dir: DIR_UP, phase: PH_FILL};
         pat_q  <= start_pat;
         cnt_q  <= '0;
         step_q <= 1'b0;
      end else if (tick) begin
         st_q.dir   <= nxt_dir;
         st_q.phase <= nxt_phase;
         pat_q      <= nxt_pat;
         cnt_q      <= '0;
         step_q     <= 1'b1;
      end else if (enable) begin
         cnt_q  <= cnt_q + DIV_W'(1);
         step_q <= 1'b0;
      end else begin
         step_q <= 1'b0;
      end
   end

   assign step = step_q;

`ifdef LED_PATTERN_PWM_EN
   logic [3:0] pwm_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pwm_q <= 4'd0;
      else        pwm_q <= pwm_q + 4'd1;
   end

   assign leds = pat_q & {NUM_LEDS{pwm_q < duty}};
`else
   assign leds = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Purpose:
//   Self-checking bench for led_pattern_gen (default build, no PWM).
//   Inputs change on the falling edge; a reference model predicts, per rising
//   edge, whether leds/step will change and pushes {step, cycle, leds} into a
//   queue. A monitor samples 1 time unit after each rising edge and pops one
//   entry whenever step is high or leds changed.
//   The model derives each pattern directly from the step index since the last
//   restart using closed-form arithmetic per mode.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

   localparam int N     = 8;
   localparam int DW    = 24;
   localparam int W     = 1 + 32 + N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [DW-1:0] div = '0;
   logic [N-1:0]  leds;
   logic          step;

   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   logic [W-1:0]  exp_q[$];

   // Reference model state
   int            m_mode = 0;
   int            m_cnt  = 0;
   int            m_k    = 0;
   logic [N-1:0]  m_leds = 1;

   led_pattern_gen #(.NUM_LEDS(N), .DIV_W(DW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .mode   (mode),
      .div    (div),
      .leds   (leds),
      .step   (step)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   // Pattern after k steps from the restart point of mode m.
   function automatic logic [N-1:0] pattern(int m, int k);
      logic [N-1:0] one;
      logic [N-1:0] ones;
      int p;
      int q;
      one  = 1;
      ones = '1;
      case (m)
         0: pattern = one << (k % N);
         1: pattern = one << (N - 1 - (k % N));
         2: begin
            p = k % (2 * N - 2);
            q = (p < N) ? p : (2 * N - 2 - p);
            pattern = one << q;
         end
         default: begin
            p = k % (2 * N);
            q = (p <= N) ? p : (2 * N - p);   // number of lit LEDs
            pattern = (q == 0) ? '0 : (ones >> (N - q));
         end
      endcase
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_cnt  = 0;
      m_k    = 0;
      m_leds = pattern(0, 0);
   endtask

   // Predict the effect of the coming rising edge.
   task automatic model_cycle(bit en, int md, int d);
      logic [N-1:0] nl;
      logic         ns;
      logic [31:0]  st;
      ns = 1'b0;
      nl = m_leds;
      st = 32'(cyc + 1);
      if (md != m_mode) begin
         m_mode = md;
         m_k    = 0;
         m_cnt  = 0;
         nl     = pattern(md, 0);
      end else if (en) begin
         if (m_cnt >= d) begin
            m_cnt = 0;
            m_k   = m_k + 1;
            ns    = 1'b1;
            nl    = pattern(m_mode, m_k);
         end else begin
            m_cnt = m_cnt + 1;
         end
      end
      if (ns || nl != m_leds) exp_q.push_back({ns, st, nl});
      m_leds = nl;
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge; returns at the next falling edge.
   task automatic drive_cycle(bit en, int md, int d);
      enable = en;
      mode   = 2'(md);
      div    = DW'(d);
      model_cycle(en, md, d);
      @(negedge clk);
   endtask

   task automatic check_direct(string name, logic [N-1:0] got_l, logic got_s,
                               logic [N-1:0] exp_l, logic exp_s);
      checks++;
      if (got_l !== exp_l || got_s !== exp_s) begin
         errors++;
         $display("FAIL %s: got leds=%h step=%b, expected leds=%h step=%b",
                  name, got_l, got_s, exp_l, exp_s);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [N-1:0] prev_leds = 1;

   always @(posedge clk) begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      #1;
      if (!rst_n) begin
         prev_leds = leds;
      end else begin
         if (step !== 1'b0 || leds !== prev_leds) begin
            got = {step, 32'(cyc), leds};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got step=%b cyc=%0d leds=%h, expected no change",
                        step, cyc, leds);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("FAIL event: got step=%b cyc=%0d leds=%h, expected step=%b cyc=%0d leds=%h",
                           got[W-1], got[W-2:N], got[N-1:0],
                           exp[W-1], exp[W-2:N], exp[N-1:0]);
               end
            end
         end
         prev_leds = leds;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int md;
      int d;
      bit en;

      // Reset state
      repeat (3) @(negedge clk);
      check_direct("reset_state", leds, step, 8'h01, 1'b0);
      model_reset();
      rst_n = 1'b1;

      // Ripple up, div = 3: one step every 4 cycles, wraps 80h -> 01h
      repeat (40) drive_cycle(1, 0, 3);

      // Bounce, div = 0
      repeat (30) drive_cycle(1, 2, 0);

      // Fill/drain, div = 0
      repeat (36) drive_cycle(1, 3, 0);

      // Mode change coincident with a tick: restart wins
      repeat (2) drive_cycle(1, 0, 3);
      while (m_cnt < 3) drive_cycle(1, 0, 3);
      drive_cycle(1, 1, 3);
      repeat (12) drive_cycle(1, 1, 3);

      // Enable dropped mid-count for 10 cycles
      repeat (2) drive_cycle(1, 1, 5);
      repeat (10) drive_cycle(0, 1, 5);
      repeat (15) drive_cycle(1, 1, 5);

      // Mode change while disabled still restarts
      repeat (3) drive_cycle(0, 2, 5);
      repeat (8) drive_cycle(1, 2, 1);

      // Lower div from 100 to 2 while the count sits at 50
      drive_cycle(1, 0, 100);
      while (m_cnt < 50) drive_cycle(1, 0, 100);
      repeat (10) drive_cycle(1, 0, 2);

      // Randomised mix of modes, divs and enable
      md = 0;
      d  = 1;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 19) == 0) md = $urandom_range(0, 3);
         if ($urandom_range(0, 29) == 0) d  = $urandom_range(0, 4);
         en = ($urandom_range(0, 7) != 0);
         drive_cycle(en, md, d);
      end

      // Reset asserted between edges: leds return to 01h without a clock
      drive_cycle(1, 1, 0);
      drive_cycle(1, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_direct("async_reset", leds, step, 8'h01, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) drive_cycle(1, 0, 1);

      // Drain: nothing may be left predicted but unseen
      repeat (5) drive_cycle(0, m_mode, 1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events: got %0d unmatched, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
